// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor whose carry ripples across
// STAGES register boundaries, one C-bit chunk per stage. A single global
// advance signal moves the whole pipeline, so a stalled output holds every
// stage in place.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int C = WIDTH / STAGES;

    generate
        if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be divisible by STAGES");
        end
    endgenerate

    // Per-stage state. a/b hold the not-yet-consumed upper chunks (skew),
    // sum holds the already-computed lower chunks (deskew). Full-width
    // vectors keep the chunk positions identical in every stage.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic              ovf_q;
    logic              ovf_d;

    logic              advance_s;
    logic [WIDTH-1:0]  b_eff_s;
    logic              cin_s;
    logic [WIDTH-1:0]  src_a_s;
    logic [WIDTH-1:0]  src_b_s;
    logic [WIDTH-1:0]  src_sum_s;
    logic              src_c_s;
    logic              src_v_s;
    logic [C:0]        chunk_s;
    int                prev_s;

    // Next-state of every stage: chunk k is added using the carry left by
    // the previous stage; stage 0 takes operands straight from the inputs.
    always_comb begin
        advance_s = !valid_q[STAGES-1] || out_ready_i;
        b_eff_s   = sub_i ? ~b_i : b_i;
        cin_s     = sub_i ? 1'b1 : carry_i;
        src_a_s   = {WIDTH{1'b0}};
        src_b_s   = {WIDTH{1'b0}};
        src_sum_s = {WIDTH{1'b0}};
        src_c_s   = 1'b0;
        src_v_s   = 1'b0;
        chunk_s   = {(C+1){1'b0}};
        prev_s    = 0;
        carry_d   = {STAGES{1'b0}};
        valid_d   = {STAGES{1'b0}};
        ovf_d     = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            prev_s = (k > 0) ? (k - 1) : 0;
            if (k == 0) begin
                src_a_s   = a_i;
                src_b_s   = b_eff_s;
                src_sum_s = {WIDTH{1'b0}};
                src_c_s   = cin_s;
                src_v_s   = in_valid_i;
            end else begin
                src_a_s   = a_q[prev_s];
                src_b_s   = b_q[prev_s];
                src_sum_s = sum_q[prev_s];
                src_c_s   = carry_q[prev_s];
                src_v_s   = valid_q[prev_s];
            end
            chunk_s = {1'b0, src_a_s[k*C +: C]} + {1'b0, src_b_s[k*C +: C]}
                    + {{C{1'b0}}, src_c_s};
            a_d[k]            = src_a_s;
            b_d[k]            = src_b_s;
            sum_d[k]          = src_sum_s;
            sum_d[k][k*C +: C] = chunk_s[C-1:0];
            carry_d[k]        = chunk_s[C];
            valid_d[k]        = src_v_s;
        end
        // Carry into the MSB is recovered from the MSB sum bit and operands.
        ovf_d = carry_d[STAGES-1]
              ^ (a_d[STAGES-1][WIDTH-1] ^ b_d[STAGES-1][WIDTH-1]
                 ^ sum_d[STAGES-1][WIDTH-1]);
    end

    // Pipeline registers: clear on reset, shift together on advance, else hold.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= {WIDTH{1'b0}};
                b_q[k]   <= {WIDTH{1'b0}};
                sum_q[k] <= {WIDTH{1'b0}};
            end
            carry_q <= {STAGES{1'b0}};
            valid_q <= {STAGES{1'b0}};
            ovf_q   <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from the last stage's registers.
    always_comb begin
        in_ready_o  = advance_s;
        out_valid_o = valid_q[STAGES-1];
        sum_o       = sum_q[STAGES-1];
        carry_o     = carry_q[STAGES-1];
        overflow_o  = ovf_q;
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed testbench for pipelined_adder: default 16/4 instance plus
// STAGES=1 and WIDTH=32/STAGES=8 instances sharing the operand buses.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_s = 32'd0;
    logic [31:0] b_s = 32'd0;
    logic        carry_s = 1'b0;
    logic        sub_s = 1'b0;
    logic        out_ready_s = 1'b1;
    logic        v4 = 1'b0, v1 = 1'b0, v8 = 1'b0;

    logic        rdy4, ov4, c4, o4;
    logic [15:0] s4;
    logic        rdy1, ov1, c1, o1;
    logic [15:0] s1;
    logic        rdy8, ov8, c8, o8;
    logic [31:0] s8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v4), .in_ready_o(rdy4),
        .a_i(a_s[15:0]), .b_i(b_s[15:0]), .carry_i(carry_s), .sub_i(sub_s),
        .out_valid_o(ov4), .out_ready_i(out_ready_s), .sum_o(s4),
        .carry_o(c4), .overflow_o(o4));

    pipelined_adder #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v1), .in_ready_o(rdy1),
        .a_i(a_s[15:0]), .b_i(b_s[15:0]), .carry_i(carry_s), .sub_i(sub_s),
        .out_valid_o(ov1), .out_ready_i(out_ready_s), .sum_o(s1),
        .carry_o(c1), .overflow_o(o1));

    pipelined_adder #(.WIDTH(32), .STAGES(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v8), .in_ready_o(rdy8),
        .a_i(a_s), .b_i(b_s), .carry_i(carry_s), .sub_i(sub_s),
        .out_valid_o(ov8), .out_ready_i(out_ready_s), .sum_o(s8),
        .carry_o(c8), .overflow_o(o8));

    // Observe one instance's outputs: 0 = 16/4, 1 = 16/1, 2 = 32/8.
    task automatic get(input int which, output logic v, output logic [31:0] s,
                       output logic c, output logic o);
        case (which)
            0: begin v = ov4; s = {16'd0, s4}; c = c4; o = o4; end
            1: begin v = ov1; s = {16'd0, s1}; c = c1; o = o1; end
            default: begin v = ov8; s = s8; c = c8; o = o8; end
        endcase
    endtask

    // One operation on one instance with exact latency and result checks.
    task automatic op(input int which, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input logic [31:0] es,
                      input logic ec, input logic eo, input string name);
        int lat;
        logic v, c, o;
        logic [31:0] s;
        lat = (which == 0) ? 4 : ((which == 1) ? 1 : 8);
        @(negedge clk);
        out_ready_s = 1'b1;
        a_s = a; b_s = b; carry_s = cin; sub_s = sub;
        v4 = (which == 0); v1 = (which == 1); v8 = (which == 2);
        for (int e = 1; e <= lat; e++) begin
            @(posedge clk);
            #1;
            v4 = 1'b0; v1 = 1'b0; v8 = 1'b0;
            get(which, v, s, c, o);
            checks++;
            if (v !== (e == lat)) begin
                errors++;
                $display("FAIL %s latency edge %0d: out_valid=%b required %b", name, e, v, (e == lat));
            end
        end
        checks++;
        if (s !== es) begin
            errors++;
            $display("FAIL %s sum: got %h required %h", name, s, es);
        end
        checks++;
        if (c !== ec) begin
            errors++;
            $display("FAIL %s carry: got %b required %b", name, c, ec);
        end
        checks++;
        if (o !== eo) begin
            errors++;
            $display("FAIL %s overflow: got %b required %b", name, o, eo);
        end
    endtask

    // Reference: A + B' + cin as a 17-bit value {carry, sum}.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        bb = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (ov4 !== 1'b0 || s4 !== 16'h0000 || c4 !== 1'b0 || o4 !== 1'b0 || rdy4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_initial: v=%b s=%h c=%b o=%b rdy=%b required 0 0000 0 0 1", ov4, s4, c4, o4, rdy4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Fill the output with a non-zero result and stall it.
        op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, "rst_prefill");
        @(negedge clk);
        out_ready_s = 1'b0;
        v4 = 1'b1; a_s = 32'h0011; b_s = 32'h0022;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov4 !== 1'b1 || s4 !== 16'h8000 || rdy4 !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: v=%b s=%h rdy=%b required 1 8000 0", ov4, s4, rdy4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov4 !== 1'b0 || s4 !== 16'h0000 || c4 !== 1'b0 || o4 !== 1'b0 || rdy4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: v=%b s=%h c=%b o=%b rdy=%b required 0 0000 0 0 1", ov4, s4, c4, o4, rdy4);
        end
        // Beats offered during reset must be dropped.
        v4 = 1'b1; a_s = 32'h1234; b_s = 32'h0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        v4 = 1'b0;
        out_ready_s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ov4 !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard cycle %0d: out_valid=%b required 0", i, ov4);
            end
        end
    endtask

    task automatic test_arith();
        op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "add_carry_all");
        op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, "add_ovf");
        op(0, 32'h1234, 32'h0F0F, 1'b1, 1'b0, 32'h2144, 1'b0, 1'b0, "add_cin");
        op(0, 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0, "sub_neg");
        op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, "sub_ovf");
    endtask

    task automatic test_bubbles();
        logic [11:0] pat;
        logic [15:0] exp_s;
        pat = 12'b0000_0100_1101;
        out_ready_s = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 4) begin
                checks++;
                if (ov4 !== pat[c-4]) begin
                    errors++;
                    $display("FAIL bubble valid cycle %0d: got %b required %b", c, ov4, pat[c-4]);
                end
                if (pat[c-4]) begin
                    exp_s = 16'((c - 4) * 257) + 16'h0011;
                    checks++;
                    if (s4 !== exp_s) begin
                        errors++;
                        $display("FAIL bubble sum cycle %0d: got %h required %h", c, s4, exp_s);
                    end
                end
            end
            v4 = pat[c];
            a_s = 32'(c * 257); b_s = 32'h0011; carry_s = 1'b0; sub_s = 1'b0;
        end
        @(negedge clk);
        v4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic [7:0]  vsub;
        logic [7:0]  vcin;
        logic [16:0] exp_r;
        logic [15:0] prev_sum;
        logic        prev_stall, acc;
        int sent, got;
        va = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hAAAA, 16'h0001, 16'h7FFF, 16'hC3C3};
        vb = '{16'h4321, 16'h0001, 16'h8000, 16'hF0F0, 16'h5555, 16'h0002, 16'hFFFF, 16'h3C3C};
        vsub = 8'b0100_1010;
        vcin = 8'b1000_1001;
        sent = 0; got = 0; prev_stall = 1'b0; prev_sum = 16'h0000;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready_s = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                v4 = 1'b1; a_s = {16'd0, va[sent]}; b_s = {16'd0, vb[sent]};
                sub_s = vsub[sent]; carry_s = vcin[sent];
            end else begin
                v4 = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (ov4 !== 1'b1 || s4 !== prev_sum) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d: v=%b s=%h required 1 %h", cyc, ov4, s4, prev_sum);
                end
            end
            if (ov4 && !out_ready_s) begin
                checks++;
                if (rdy4 !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready cycle %0d: got %b required 0", cyc, rdy4);
                end
            end
            if (ov4 && out_ready_s) begin
                exp_r = model(va[got], vb[got], vcin[got], vsub[got]);
                checks++;
                if ({c4, s4} !== exp_r) begin
                    errors++;
                    $display("FAIL bp_result %0d: got %b/%h required %b/%h", got, c4, s4, exp_r[16], exp_r[15:0]);
                end
                got++;
            end
            prev_stall = ov4 && !out_ready_s;
            prev_sum = s4;
            acc = v4 && rdy4;
            @(posedge clk);
            if (acc) sent++;
        end
        @(negedge clk);
        v4 = 1'b0;
        out_ready_s = 1'b1;
        checks++;
        if (got != 8 || sent != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d results, sent %0d, required 8 and 8", got, sent);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ov4 !== 1'b0) begin
                errors++;
                $display("FAIL bp_no_dup cycle %0d: out_valid=%b required 0", i, ov4);
            end
        end
    endtask

    task automatic test_depths();
        op(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "s1_carry_all");
        op(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, "s1_ovf");
        op(1, 32'h1234, 32'h0F0F, 1'b1, 1'b0, 32'h2144, 1'b0, 1'b0, "s1_cin");
        op(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "w32_carry_all");
        op(2, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "w32_ovf");
        op(2, 32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h21436588, 1'b0, 1'b0, "w32_cin");
    endtask

    // Sequence all scenarios, then report.
    initial begin
        test_reset();
        test_arith();
        test_bubbles();
        test_back_to_back();
        test_depths();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshakes at input and output. It is the sequential successor to the combinational half/full-adder chain. The carry ripples across STAGES register boundaries, one chunk per stage, so wide adds close timing at the ALU clock. It sits between the operand-fetch logic and the ALU result mux, and accepts one operation per cycle when not stalled.

## Interface
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES (elaboration error otherwise).
- STAGES, 4, pipeline depth and number of carry chunks. Chunk width C = WIDTH/STAGES. STAGES=1 gives a single registered adder.

- clk_i  input  1  single clock, rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  operand beat valid.
- in_ready_o  output  1  block can accept a beat this cycle.
- a_i  input  WIDTH  operand A (unsigned/two's complement).
- b_i  input  WIDTH  operand B.
- carry_i  input  1  carry-in; used only when sub_i=0.
- sub_i  input  1  1: compute A - B; 0: compute A + B + carry_i.
- out_valid_o  output  1  result beat valid.
- out_ready_i  input  1  downstream accepts result.
- sum_o  output  WIDTH  result.
- carry_o  output  1  carry-out of MSB. For sub this is NOT borrow (1 = no borrow).
- overflow_o  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective B' = sub_i ? ~b_i : b_i. Effective cin = sub_i ? 1 : carry_i.
- Stage k (0..STAGES-1) adds chunk k of A and B' (bits k*C+C-1 : k*C) plus the carry registered by stage k-1. Stage 0 uses cin.
- Skew registers carry the unconsumed upper chunks of A and B' forward with the beat. Deskew registers carry the already-computed lower sum chunks forward. Chunk alignment at the output is exact.
- Each stage holds a valid bit. Bubbles propagate as invalid entries and never produce out_valid_o.
- Global advance = !out_valid_o || out_ready_i. When advance=1, every stage register (data and valid) shifts one stage. When advance=0, all stages hold.
- in_ready_o = advance (combinational from out_valid_o, out_ready_i). A beat is accepted when in_valid_i && in_ready_o.
- overflow_o is derived in the final stage from the carry into bit WIDTH-1 and the carry out of it.
- Results emerge in acceptance order; there is no reordering and no drop.

## Timing
- Reset (rst_n_i low, asynchronous): all valid bits = 0, out_valid_o = 0, sum_o = 0, carry_o = 0, overflow_o = 0, all skew/deskew/carry registers = 0.
- While in reset, in_ready_o = 1. Beats presented during reset are not accepted and are not retained.
- Reset asserted mid-operation: in-flight beats are discarded immediately. The first post-reset output can only come from a beat accepted after reset release.
- Latency: a beat accepted at edge N presents out_valid_o=1 after edge N+STAGES-1, assuming no stall in between.
- Throughput: 1 beat/cycle while out_ready_i=1.
- Output hold: while out_valid_o=1 && out_ready_i=0, sum_o/carry_o/overflow_o/out_valid_o are stable.
- Simultaneous accept and output handshake in the same cycle is legal and required for full throughput.
- Outputs change only on the clock edge or on reset assertion.

## Test plan
All scenarios use WIDTH=16, STAGES=4 unless noted.
- Reset: drive rst_n_i=0 mid-run -> out_valid_o=0, sum_o=0x0000, carry_o=0, overflow_o=0, in_ready_o=1 with no clock edge required.
- Add with carry across all chunks: A=0xFFFF, B=0x0001, carry_i=0, sub_i=0 -> sum_o=0x0000, carry_o=1, overflow_o=0, out_valid_o exactly 4 edges after accept.
- Signed overflow: A=0x7FFF, B=0x0001 add -> sum_o=0x8000, carry_o=0, overflow_o=1. Also A=0x1234, B=0x0F0F, carry_i=1 -> sum_o=0x2144.
- Subtract: A=0x0005, B=0x0007, sub_i=1, carry_i=1 (ignored) -> sum_o=0xFFFE, carry_o=0, overflow_o=0. Also A=0x8000 - B=0x0001 -> sum_o=0x7FFF, carry_o=1, overflow_o=1.
- Backpressure: stream 8 back-to-back random beats, hold out_ready_i=0 for 3 cycles mid-stream -> in_ready_o=0 during the stall, outputs held stable, all 8 results match the reference model in order, none lost or duplicated.
- Bubbles and degenerate depth: interleave in_valid_i gaps -> out_valid_o gaps mirror the input gaps at 4-cycle latency. Rerun the add cases with STAGES=1 and with WIDTH=32, STAGES=8 -> same results, latency 1 and 8 respectively.
